// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding, default reset PC
// and the PC alignment helper (instructions are halfword aligned).
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // PC bit 0 is always forced to zero on every load.
  function automatic logic [15:0] align_pc(input logic [15:0] pc);
    return {pc[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// pc_reg: 16-bit load-enable register holding the architectural PC.
// Ports:
//   clk     - clock, updates on posedge
//   rst     - synchronous active-high reset, loads RESET_PC
//   load_en - load d into q this cycle
//   d       - next PC value (already aligned by the caller)
//   q       - current PC
module pc_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (load_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the architectural PC and fetches one instruction at a
// time over a req/gnt + rvalid memory interface, buffering it for decode.
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   pc_o / next_pc_i         - current PC out, next PC from pc_control in
//   halt_i                   - instruction being accepted is HLT
//   flush_i / flush_pc_i     - redirect request and target
//   imem_req_o / imem_addr_o - fetch request and address (= pc_o)
//   imem_gnt_i               - memory accepted the request
//   imem_rvalid_i / imem_rdata_i - read response
//   if_valid_o / if_instr_o / if_pc_o - buffered instruction to decode
//   id_ready_i               - decode accepts the buffered instruction
//   halted_o                 - core halted (left only through rst)
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          INSTR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [15:0]        pc_o,
  input  logic [15:0]        next_pc_i,
  input  logic               halt_i,
  input  logic               flush_i,
  input  logic [15:0]        flush_pc_i,
  output logic               imem_req_o,
  output logic [15:0]        imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [15:0]        if_pc_o,
  input  logic               id_ready_i,
  output logic               halted_o
);

  fetch_state_e state_q, state_d;
  logic         drop_q, drop_d;
  logic         pc_load;
  logic [15:0]  pc_d;
  logic         capture;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load_en (pc_load),
    .d       (pc_d),
    .q       (pc_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_instr_o <= '0;
      if_pc_o    <= '0;
    end else if (capture) begin
      if_instr_o <= imem_rdata_i;
      if_pc_o    <= pc_o;
    end
  end

  // Flush outranks every other event in all states except HALT. A flush that
  // coincides with a grant (or lands while waiting) leaves a response in
  // flight, which drop marks for discarding.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    pc_load = 1'b0;
    pc_d    = pc_o;
    capture = 1'b0;
    case (state_q)
      S_REQ: begin
        if (flush_i) begin
          pc_load = 1'b1;
          pc_d    = align_pc(flush_pc_i);
          if (imem_gnt_i) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end else if (imem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          pc_load = 1'b1;
          pc_d    = align_pc(flush_pc_i);
          if (imem_rvalid_i) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (drop_q) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          pc_load = 1'b1;
          pc_d    = align_pc(flush_pc_i);
          state_d = S_REQ;
        end else if (id_ready_i) begin
          if (halt_i) begin
            state_d = S_HALT;
          end else begin
            pc_load = 1'b1;
            pc_d    = align_pc(next_pc_i);
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign imem_req_o  = (state_q == S_REQ);
  assign imem_addr_o = pc_o;
  assign if_valid_o  = (state_q == S_HOLD);
  assign halted_o    = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_o;
  logic [15:0] next_pc_i;
  logic        halt_i;
  logic        flush_i;
  logic [15:0] flush_pc_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [15:0] imem_rdata_i;
  logic        if_valid_o;
  logic [15:0] if_instr_o;
  logic [15:0] if_pc_o;
  logic        id_ready_i;
  logic        halted_o;

  pc_fetch_unit #(.RESET_PC(RST_PC), .INSTR_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_o          (pc_o),
    .next_pc_i     (next_pc_i),
    .halt_i        (halt_i),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .id_ready_i    (id_ready_i),
    .halted_o      (halted_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: tracks the fetch pipe as a few independent facts
  // (halted, instruction buffered, request in flight, response to discard)
  // rather than as a state machine.
  logic [15:0] m_pc;
  bit          m_halted;
  bit          m_buffered;
  bit          m_in_flight;
  bit          m_discard;
  logic [15:0] m_instr;
  logic [15:0] m_ipc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit m_requesting();
    return !m_halted && !m_buffered && !m_in_flight;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_halted = 0; m_buffered = 0; m_in_flight = 0;
    m_discard = 0; m_instr = 16'h0; m_ipc = 16'h0;
  endtask

  task automatic compare_all();
    check("pc",       {16'h0, pc_o},        {16'h0, m_pc});
    check("addr",     {16'h0, imem_addr_o}, {16'h0, m_pc});
    check("req",      {31'h0, imem_req_o},  {31'h0, m_requesting()});
    check("if_valid", {31'h0, if_valid_o},  {31'h0, m_buffered});
    check("halted",   {31'h0, halted_o},    {31'h0, m_halted});
    check("if_instr", {16'h0, if_instr_o},  {16'h0, m_instr});
    check("if_pc",    {16'h0, if_pc_o},     {16'h0, m_ipc});
  endtask

  // Applies one cycle of inputs, checks current outputs against the model,
  // then advances the model across the clock edge.
  task automatic cyc(input bit g, input bit rv, input logic [15:0] rd,
                     input bit rdy, input bit hl, input logic [15:0] npc,
                     input bit fl, input logic [15:0] fpc, input bit r);
    bit req_now;
    imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rd;
    id_ready_i = rdy; halt_i = hl; next_pc_i = npc;
    flush_i = fl; flush_pc_i = fpc; rst = r;
    #1;
    compare_all();
    req_now = m_requesting();
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (!m_halted) begin
      if (fl) begin
        m_pc = fpc & 16'hFFFE;
        m_buffered = 0;
        if (req_now && g) begin
          m_in_flight = 1; m_discard = 1;
        end else if (m_in_flight) begin
          if (rv) begin m_in_flight = 0; m_discard = 0; end
          else m_discard = 1;
        end
      end else if (req_now && g) begin
        m_in_flight = 1;
      end else if (m_in_flight && rv) begin
        m_in_flight = 0;
        if (m_discard) m_discard = 0;
        else begin m_buffered = 1; m_instr = rd; m_ipc = m_pc; end
      end else if (m_buffered && rdy) begin
        m_buffered = 0;
        if (hl) m_halted = 1;
        else m_pc = npc & 16'hFFFE;
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 0);
  endtask

  task automatic fetch(input logic [15:0] data);
    cyc(1, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 0);
    cyc(0, 1, data, 0, 0, 16'h0, 0, 16'h0, 0);
  endtask

  task automatic accept(input logic [15:0] npc, input bit hl);
    cyc(0, 0, 16'h0, 1, hl, npc, 0, 16'h0, 0);
  endtask

  initial begin
    rst = 1; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    id_ready_i = 0; halt_i = 0; next_pc_i = 0; flush_i = 0; flush_pc_i = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;

    // reset state
    check("rst_pc",    {16'h0, pc_o}, 32'h0);
    check("rst_req",   {31'h0, imem_req_o}, 32'h1);
    check("rst_valid", {31'h0, if_valid_o}, 32'h0);
    check("rst_halt",  {31'h0, halted_o}, 32'h0);

    // basic fetch and hold
    check("t1_addr", {16'h0, imem_addr_o}, 32'h0);
    fetch(16'hA123);
    check("t1_valid", {31'h0, if_valid_o}, 32'h1);
    check("t1_instr", {16'h0, if_instr_o}, 32'hA123);
    check("t1_ifpc",  {16'h0, if_pc_o}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("t2_instr", {16'h0, if_instr_o}, 32'hA123);
      check("t2_req",   {31'h0, imem_req_o}, 32'h0);
    end
    accept(16'h0002, 0);
    check("t1_next_addr", {16'h0, imem_addr_o}, 32'h2);

    // flush while waiting; late response discarded
    cyc(1, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 1, 16'h0040, 0);
    idle();
    cyc(0, 1, 16'hBEEF, 0, 0, 16'h0, 0, 16'h0, 0);
    check("t3_valid", {31'h0, if_valid_o}, 32'h0);
    check("t3_addr",  {16'h0, imem_addr_o}, 32'h40);
    check("t3_req",   {31'h0, imem_req_o}, 32'h1);

    // alignment and wrap
    fetch(16'h1111); accept(16'h0101, 0);
    check("t5_align", {16'h0, pc_o}, 32'h0100);
    fetch(16'h2222); accept(16'hFFFE, 0);
    fetch(16'h3333); accept(16'h0000, 0);
    check("t5_wrap", {16'h0, imem_addr_o}, 32'h0);

    // flush and accept together: flush target wins
    fetch(16'h4444);
    cyc(0, 0, 16'h0, 1, 0, 16'h1234, 1, 16'h0080, 0);
    check("t6_pc", {16'h0, pc_o}, 32'h0080);

    // reset in WAIT then stale rvalid
    cyc(1, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 1);
    cyc(0, 1, 16'h5555, 0, 0, 16'h0, 0, 16'h0, 0);
    check("t7_req",   {31'h0, imem_req_o}, 32'h1);
    check("t7_pc",    {16'h0, pc_o}, {16'h0, RST_PC});
    check("t7_valid", {31'h0, if_valid_o}, 32'h0);

    // halt
    fetch(16'h6666); accept(16'h0010, 1);
    check("t4_halted", {31'h0, halted_o}, 32'h1);
    cyc(1, 1, 16'h7777, 1, 0, 16'h0020, 1, 16'h0030, 0);
    cyc(1, 1, 16'h7777, 1, 0, 16'h0020, 1, 16'h0030, 0);
    check("t4_stuck", {31'h0, halted_o}, 32'h1);
    check("t4_noreq", {31'h0, imem_req_o}, 32'h0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 1);
    check("t4_rst_halt", {31'h0, halted_o}, 32'h0);
    check("t4_rst_req",  {31'h0, imem_req_o}, 32'h1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 1), 16'($urandom),
          $urandom_range(0, 1), ($urandom_range(0, 31) == 0),
          16'($urandom), ($urandom_range(0, 15) == 0), 16'($urandom),
          ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
